// File: rtl/seg_scan_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// seg_scan_pkg : shared constants, scan FSM states and digit extraction helper
// Revision     : 1.0
// ----------------------------------------------------------------------------
package seg_scan_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int SEG_W      = 7;
  localparam int DIG_IDX_W  = 2;

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_ON    = 1'b1;

  typedef enum logic [0:0] {
    BLANK = ST_BLANK,
    ON    = ST_ON
  } scan_state_e;

  function automatic logic [SEG_W-1:0] digit_segs(
    input logic [NUM_DIGITS*SEG_W-1:0] word,
    input logic [DIG_IDX_W-1:0]        idx
  );
    return word[SEG_W*idx +: SEG_W];
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg_scan_timer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// seg_scan_timer : slot/digit/PWM counters and BLANK/ON phase sequencing
// Revision       : 1.0
// ----------------------------------------------------------------------------
module seg_scan_timer
  import seg_scan_pkg::*;
#(
  parameter int SCAN_DIV     = 1024,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic [DIG_IDX_W-1:0] digit_idx_o,
  output logic [3:0]           pwm_cnt_o,
  output logic                 blank_o,
  output logic                 slot_wrap_o,
  output logic                 frame_wrap_o
);

  localparam int CNT_W = $clog2(SCAN_DIV);

  logic [CNT_W-1:0]     slot_cnt_q, slot_cnt_d;
  logic [DIG_IDX_W-1:0] digit_idx_q, digit_idx_d;
  logic [3:0]           pwm_cnt_q, pwm_cnt_d;
  scan_state_e          state_q, state_d;
  logic                 slot_wrap;

  assign slot_wrap = (slot_cnt_q == CNT_W'(SCAN_DIV - 1));

  always_comb begin
    slot_cnt_d  = slot_wrap ? '0 : slot_cnt_q + 1'b1;
    digit_idx_d = slot_wrap ? digit_idx_q + 1'b1 : digit_idx_q;
    // PWM phase only advances while lit so duty is measured over ON time
    pwm_cnt_d   = (state_q == ON) ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
    state_d     = state_q;
    case (state_q)
      BLANK:   if (slot_cnt_q == CNT_W'(BLANK_CYCLES - 1)) state_d = ON;
      ON:      if (slot_wrap) state_d = BLANK;
      default: state_d = BLANK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_cnt_q  <= '0;
      digit_idx_q <= '0;
      pwm_cnt_q   <= '0;
      state_q     <= BLANK;
    end else begin
      slot_cnt_q  <= slot_cnt_d;
      digit_idx_q <= digit_idx_d;
      pwm_cnt_q   <= pwm_cnt_d;
      state_q     <= state_d;
    end
  end

  assign digit_idx_o  = digit_idx_q;
  assign pwm_cnt_o    = pwm_cnt_q;
  assign blank_o      = (state_q == BLANK);
  assign slot_wrap_o  = slot_wrap;
  assign frame_wrap_o = slot_wrap && (digit_idx_q == DIG_IDX_W'(NUM_DIGITS - 1));

endmodule
`default_nettype wire

// File: rtl/seg_scan_driver.sv
`default_nettype none
// ----------------------------------------------------------------------------
// seg_scan_driver : four-digit multiplexed 7-segment driver with PWM dimming
//                   and frame-aligned shadowing. SEG_SCAN_BLINK_EN adds blink.
// Revision        : 1.0
// ----------------------------------------------------------------------------
module seg_scan_driver
  import seg_scan_pkg::*;
#(
  parameter int SCAN_DIV       = 1024,
  parameter int BLANK_CYCLES   = 16,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_DIGITS*SEG_W-1:0] seg_data,
  input  logic [3:0]                  brightness,
`ifdef SEG_SCAN_BLINK_EN
  input  logic [NUM_DIGITS-1:0]       blink_mask,
`endif
  output logic [SEG_W-1:0]            seg_out,
  output logic [NUM_DIGITS-1:0]       dig_en,
  output logic                        frame_tick
);

  localparam logic [SEG_W-1:0]      SEG_OFF = (SEG_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [NUM_DIGITS-1:0] DIG_OFF = (DIG_ACTIVE_LOW != 0) ? '1 : '0;

  logic [DIG_IDX_W-1:0]        digit_idx;
  logic [3:0]                  pwm_cnt;
  logic                        blank;
  logic                        frame_wrap;
  logic                        slot_wrap_unused;

  logic [NUM_DIGITS*SEG_W-1:0] shadow_q;
  logic [SEG_W-1:0]            seg_out_q, seg_out_d, seg_lit;
  logic [NUM_DIGITS-1:0]       dig_en_q, dig_en_d, dig_lit;
  logic                        frame_tick_q;
  logic                        lit_en;

  seg_scan_timer #(
    .SCAN_DIV     (SCAN_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .clk          (clk),
    .reset        (reset),
    .digit_idx_o  (digit_idx),
    .pwm_cnt_o    (pwm_cnt),
    .blank_o      (blank),
    .slot_wrap_o  (slot_wrap_unused),
    .frame_wrap_o (frame_wrap)
  );

`ifdef SEG_SCAN_BLINK_EN
  logic [NUM_DIGITS-1:0] blink_q;
  logic [5:0]            frame_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      blink_q     <= '0;
      frame_cnt_q <= '0;
    end else if (frame_wrap) begin
      blink_q     <= blink_mask;
      frame_cnt_q <= frame_cnt_q + 1'b1;
    end
  end
`endif

  always_comb begin
    lit_en = !blank && ((brightness == 4'hF) || (pwm_cnt < brightness));
`ifdef SEG_SCAN_BLINK_EN
    // Upper half of the 64-frame cycle is the dark phase of the blink
    lit_en = lit_en && !(blink_q[digit_idx] && frame_cnt_q[5]);
`endif
    seg_lit   = lit_en ? digit_segs(shadow_q, digit_idx) : '0;
    dig_lit   = lit_en ? (NUM_DIGITS'(1) << digit_idx) : '0;
    seg_out_d = (SEG_ACTIVE_LOW != 0) ? ~seg_lit : seg_lit;
    dig_en_d  = (DIG_ACTIVE_LOW != 0) ? ~dig_lit : dig_lit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q     <= '0;
      seg_out_q    <= SEG_OFF;
      dig_en_q     <= DIG_OFF;
      frame_tick_q <= 1'b0;
    end else begin
      if (frame_wrap) shadow_q <= seg_data;
      seg_out_q    <= seg_out_d;
      dig_en_q     <= dig_en_d;
      frame_tick_q <= frame_wrap;
    end
  end

  assign seg_out    = seg_out_q;
  assign dig_en     = dig_en_q;
  assign frame_tick = frame_tick_q;

endmodule
`default_nettype wire
